// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, exception codes and the EX-stage entry record
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_PC_W   = 30;
  localparam int CPU_REG_W  = 5;
  localparam int CPU_EXP_W  = 3;

  localparam logic [1:0] MEM_OP_NOP  = 2'b00;
  localparam logic [1:0] CTRL_OP_NOP = 2'b00;

  localparam logic [CPU_EXP_W-1:0] EXP_NO_EXP     = 3'd0;
  localparam logic [CPU_EXP_W-1:0] EXP_EXT_INT    = 3'd1;
  localparam logic [CPU_EXP_W-1:0] EXP_UNDEF_INSN = 3'd2;
  localparam logic [CPU_EXP_W-1:0] EXP_OVERFLOW   = 3'd3;

  typedef struct packed {
    logic [CPU_PC_W-1:0]   pc;
    logic                  en;
    logic                  br_flag;
    logic [1:0]            mem_op;
    logic [CPU_DATA_W-1:0] mem_wr_data;
    logic [1:0]            ctrl_op;
    logic [CPU_REG_W-1:0]  dst_addr;
    logic                  gpr_we_;
    logic [CPU_EXP_W-1:0]  exp_code;
    logic [CPU_DATA_W-1:0] result;
  } ex_entry_t;

  localparam ex_entry_t EX_ENTRY_RESET = '{
    pc: '0, en: 1'b0, br_flag: 1'b0, mem_op: MEM_OP_NOP, mem_wr_data: '0,
    ctrl_op: CTRL_OP_NOP, dst_addr: '0, gpr_we_: 1'b1, exp_code: EXP_NO_EXP,
    result: '0
  };

  // A faulting instruction keeps its pc/en/br_flag so the exception handler
  // can locate it, but must not touch memory, control flow or the register file.
  function automatic ex_entry_t squash_entry(input ex_entry_t e,
                                             input logic [CPU_EXP_W-1:0] code);
    ex_entry_t s;
    s             = e;
    s.mem_op      = MEM_OP_NOP;
    s.ctrl_op     = CTRL_OP_NOP;
    s.dst_addr    = '0;
    s.gpr_we_     = 1'b1;
    s.mem_wr_data = '0;
    s.result      = '0;
    s.exp_code    = code;
    return s;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// rtl/ex_stage_pipe_if.sv - upstream instruction/ALU capture bus into the EX stage
interface ex_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_W  = 5,
  parameter int EXP_W  = 3
);
  logic [PC_W-1:0]   in_pc;
  logic              in_en;
  logic              in_br_flag;
  logic [1:0]        in_mem_op;
  logic [DATA_W-1:0] in_mem_wr_data;
  logic [1:0]        in_ctrl_op;
  logic [REG_W-1:0]  in_dst_addr;
  logic              in_gpr_we_;
  logic [EXP_W-1:0]  in_exp_code;
  logic [DATA_W-1:0] alu_out;
  logic              alu_of;
  logic              int_detect;

  modport master (
    output in_pc, in_en, in_br_flag, in_mem_op, in_mem_wr_data, in_ctrl_op,
           in_dst_addr, in_gpr_we_, in_exp_code, alu_out, alu_of, int_detect
  );

  modport slave (
    input in_pc, in_en, in_br_flag, in_mem_op, in_mem_wr_data, in_ctrl_op,
          in_dst_addr, in_gpr_we_, in_exp_code, alu_out, alu_of, int_detect
  );
endinterface

// File: rtl/ex_exc_squash.sv
// rtl/ex_exc_squash.sv - combinational exception prioritisation and entry squash
module ex_exc_squash
  import cpu_pkg::*;
(
  ex_stage_pipe_if.slave cap,
  output ex_entry_t      entry
);

  ex_entry_t raw;

  always_comb begin
    raw.pc          = cap.in_pc;
    raw.en          = cap.in_en;
    raw.br_flag     = cap.in_br_flag;
    raw.mem_op      = cap.in_mem_op;
    raw.mem_wr_data = cap.in_mem_wr_data;
    raw.ctrl_op     = cap.in_ctrl_op;
    raw.dst_addr    = cap.in_dst_addr;
    raw.gpr_we_     = cap.in_gpr_we_;
    raw.exp_code    = cap.in_exp_code;
    raw.result      = cap.alu_out;
  end

  // Interrupt beats an earlier-stage exception, which beats a fresh overflow.
  always_comb begin
    entry = raw;
    if (cap.int_detect) begin
      entry = squash_entry(raw, EXP_EXT_INT);
    end else if (cap.in_exp_code != EXP_NO_EXP) begin
      entry = squash_entry(raw, cap.in_exp_code);
    end else if (cap.alu_of) begin
      entry = squash_entry(raw, EXP_OVERFLOW);
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - EX/MEM pipeline register with optional skid entry and flush
module ex_stage_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_W  = 5,
  parameter int EXP_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_en,
  input  logic              in_br_flag,
  input  logic [1:0]        in_mem_op,
  input  logic [DATA_W-1:0] in_mem_wr_data,
  input  logic [1:0]        in_ctrl_op,
  input  logic [REG_W-1:0]  in_dst_addr,
  input  logic              in_gpr_we_,
  input  logic [EXP_W-1:0]  in_exp_code,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_of,
  input  logic              int_detect,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_en,
  output logic              out_br_flag,
  output logic [1:0]        out_mem_op,
  output logic [DATA_W-1:0] out_mem_wr_data,
  output logic [1:0]        out_ctrl_op,
  output logic [REG_W-1:0]  out_dst_addr,
  output logic              out_gpr_we_,
  output logic [EXP_W-1:0]  out_exp_code,
  output logic [DATA_W-1:0] out_result,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  ex_stage_pipe_if #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .EXP_W(EXP_W)
  ) cap_bus ();

  assign cap_bus.in_pc          = in_pc;
  assign cap_bus.in_en          = in_en;
  assign cap_bus.in_br_flag     = in_br_flag;
  assign cap_bus.in_mem_op      = in_mem_op;
  assign cap_bus.in_mem_wr_data = in_mem_wr_data;
  assign cap_bus.in_ctrl_op     = in_ctrl_op;
  assign cap_bus.in_dst_addr    = in_dst_addr;
  assign cap_bus.in_gpr_we_     = in_gpr_we_;
  assign cap_bus.in_exp_code    = in_exp_code;
  assign cap_bus.alu_out        = alu_out;
  assign cap_bus.alu_of         = alu_of;
  assign cap_bus.int_detect     = int_detect;

  ex_entry_t cap_entry;

  ex_exc_squash u_squash (
    .cap   (cap_bus),
    .entry (cap_entry)
  );

  ex_entry_t  head_q, head_d;
  ex_entry_t  skid_q, skid_d;
  logic [1:0] occ_q, occ_d;
  logic       rdy_q, rdy_d;
  logic       acc, pop;

  assign acc = in_valid && rdy_q;
  assign pop = (occ_q != 2'd0) && out_ready;

  // The skid slot only fills when the head stalls; rdy_q already blocks
  // accepts at full occupancy, so acc never coincides with occ_q == 2.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = EX_ENTRY_RESET;
      skid_d = EX_ENTRY_RESET;
      occ_d  = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (acc) begin
            head_d = cap_entry;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (acc && pop) begin
            head_d = cap_entry;
          end else if (pop) begin
            head_d = EX_ENTRY_RESET;
            occ_d  = 2'd0;
          end else if (acc) begin
            skid_d = cap_entry;
            occ_d  = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_d = skid_q;
            skid_d = EX_ENTRY_RESET;
            occ_d  = 2'd1;
          end
        end
      endcase
    end
    rdy_d = (occ_d < DEPTH_L);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= EX_ENTRY_RESET;
      skid_q <= EX_ENTRY_RESET;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready        = rdy_q;
  assign occupancy       = occ_q;
  assign out_valid       = (occ_q != 2'd0);
  assign out_pc          = head_q.pc;
  assign out_en          = head_q.en;
  assign out_br_flag     = head_q.br_flag;
  assign out_mem_op      = head_q.mem_op;
  assign out_mem_wr_data = head_q.mem_wr_data;
  assign out_ctrl_op     = head_q.ctrl_op;
  assign out_dst_addr    = head_q.dst_addr;
  assign out_gpr_we_     = head_q.gpr_we_;
  assign out_exp_code    = head_q.exp_code;
  assign out_result      = head_q.result;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed and randomized checks of ex_stage_pipe
module tb_ex_stage_pipe;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [29:0] out_pc;
  logic        out_en, out_br_flag, out_gpr_we_;
  logic [1:0]  out_mem_op, out_ctrl_op, occupancy;
  logic [31:0] out_mem_wr_data, out_result;
  logic [4:0]  out_dst_addr;
  logic [2:0]  out_exp_code;

  ex_stage_pipe_if up ();

  ex_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(up.in_pc), .in_en(up.in_en), .in_br_flag(up.in_br_flag),
    .in_mem_op(up.in_mem_op), .in_mem_wr_data(up.in_mem_wr_data),
    .in_ctrl_op(up.in_ctrl_op), .in_dst_addr(up.in_dst_addr),
    .in_gpr_we_(up.in_gpr_we_), .in_exp_code(up.in_exp_code),
    .alu_out(up.alu_out), .alu_of(up.alu_of), .int_detect(up.int_detect),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
    .out_mem_op(out_mem_op), .out_mem_wr_data(out_mem_wr_data),
    .out_ctrl_op(out_ctrl_op), .out_dst_addr(out_dst_addr),
    .out_gpr_we_(out_gpr_we_), .out_exp_code(out_exp_code),
    .out_result(out_result), .occupancy(occupancy)
  );

  int checks = 0;
  int fails  = 0;
  ex_entry_t model_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the stage should record for the instruction on the bus now.
  function automatic ex_entry_t model_capture();
    ex_entry_t e;
    logic [2:0] code;
    logic faulted;
    faulted = 1'b1;
    if (up.int_detect)              code = 3'd1;
    else if (up.in_exp_code != 3'd0) code = up.in_exp_code;
    else if (up.alu_of)             code = 3'd3;
    else begin code = 3'd0; faulted = 1'b0; end
    e.pc          = up.in_pc;
    e.en          = up.in_en;
    e.br_flag     = up.in_br_flag;
    e.exp_code    = code;
    e.mem_op      = faulted ? 2'b00 : up.in_mem_op;
    e.ctrl_op     = faulted ? 2'b00 : up.in_ctrl_op;
    e.dst_addr    = faulted ? 5'd0 : up.in_dst_addr;
    e.gpr_we_     = faulted ? 1'b1 : up.in_gpr_we_;
    e.mem_wr_data = faulted ? 32'd0 : up.in_mem_wr_data;
    e.result      = faulted ? 32'd0 : up.alu_out;
    return e;
  endfunction

  function automatic ex_entry_t observed();
    ex_entry_t e;
    e = '{pc: out_pc, en: out_en, br_flag: out_br_flag, mem_op: out_mem_op,
          mem_wr_data: out_mem_wr_data, ctrl_op: out_ctrl_op,
          dst_addr: out_dst_addr, gpr_we_: out_gpr_we_,
          exp_code: out_exp_code, result: out_result};
    return e;
  endfunction

  ex_entry_t reset_entry;

  task automatic step();
    ex_entry_t cap;
    bit acc, pop;
    @(negedge clk);
    chk("occupancy", 128'(occupancy), 128'(model_q.size()));
    chk("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
    if (model_q.size() > 0) chk("head_entry", 128'(observed()), 128'(model_q[0]));
    else                    chk("idle_entry", 128'(observed()), 128'(reset_entry));
    acc = in_valid && (model_q.size() < 2);
    pop = out_ready && (model_q.size() > 0);
    cap = model_capture();
    @(posedge clk);
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(cap);
    end
    #1;
  endtask

  task automatic drive(input logic [29:0] pc, input logic [31:0] alu, input logic of,
                       input logic intd, input logic [1:0] mop, input logic [2:0] ec,
                       input logic [4:0] dst, input logic we_);
    up.in_pc = pc; up.alu_out = alu; up.alu_of = of; up.int_detect = intd;
    up.in_mem_op = mop; up.in_exp_code = ec; up.in_dst_addr = dst; up.in_gpr_we_ = we_;
    up.in_en = 1'b1; up.in_br_flag = pc[0]; up.in_ctrl_op = pc[2:1];
    up.in_mem_wr_data = {pc[15:0], alu[15:0]};
  endtask

  task automatic rand_drive();
    drive($urandom, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          2'($urandom), ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
          5'($urandom), 1'($urandom));
    up.in_en = 1'($urandom);
    up.in_mem_wr_data = $urandom;
  endtask

  initial begin
    reset_entry = '{pc: '0, en: 1'b0, br_flag: 1'b0, mem_op: 2'b00, mem_wr_data: '0,
                    ctrl_op: 2'b00, dst_addr: '0, gpr_we_: 1'b1, exp_code: 3'd0,
                    result: '0};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(30'h0, 32'h0, 1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("reset_gpr_we_", 128'(out_gpr_we_), 128'(1'b1));

    // plain pass
    drive(30'h10, 32'h1234, 1'b0, 1'b0, 2'b10, 3'd0, 5'd7, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pass_valid", 128'(out_valid), 128'(1'b1));
    chk("pass_result", 128'(out_result), 128'(32'h1234));
    chk("pass_dst", 128'(out_dst_addr), 128'(5'd7));
    chk("pass_exp", 128'(out_exp_code), 128'(3'd0));
    step();

    // interrupt wins over overflow
    drive(30'h10, 32'h55, 1'b1, 1'b1, 2'b01, 3'd0, 5'd9, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; up.int_detect = 1'b0; up.alu_of = 1'b0;
    chk("int_exp", 128'(out_exp_code), 128'(3'd1));
    chk("int_mem_op", 128'(out_mem_op), 128'(2'b00));
    chk("int_gpr_we_", 128'(out_gpr_we_), 128'(1'b1));
    chk("int_pc", 128'(out_pc), 128'(30'h10));
    step();

    // upstream exception kept over overflow
    drive(30'h14, 32'hdead, 1'b1, 1'b0, 2'b11, 3'd2, 5'd3, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("upexc_exp", 128'(out_exp_code), 128'(3'd2));
    chk("upexc_result", 128'(out_result), 128'(32'd0));
    step();

    // back-pressure: three attempts, two taken, drained in order
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(30'h100 + 30'(i), 32'h1000 + 32'(i), 1'b0, 1'b0, 2'b00, 3'd0, 5'(i + 1), 1'b0);
      step();
      chk("bp_occupancy", 128'(occupancy), 128'((i == 0) ? 1 : 2));
    end
    chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_second_pc", 128'(out_pc), 128'(30'h101));
    repeat (2) step();

    // flush with simultaneous accept at full occupancy
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin rand_drive(); step(); end
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occupancy", 128'(occupancy), 128'(2'd0));
    chk("flush_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    step();

    // reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0;
    drive(30'h200, 32'h77, 1'b0, 1'b0, 2'b01, 3'd0, 5'd4, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_entry", 128'(observed()), 128'(reset_entry));
    chk("rst_occupancy", 128'(occupancy), 128'(2'd0));
    chk("rst_ready_valid", 128'({in_ready, out_valid}), 128'(2'b10));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL take these parameters:
- DATA_W, 32: ALU result and memory-write-data width.
- PC_W, 30: word-address PC width.
- REG_W, 5: destination register address width.
- EXP_W, 3: exception code width.
- DEPTH, 2: buffer entries; legal values are 1 (plain register) and 2 (skid buffer).

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have these ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: upstream entry valid.
- in_ready, out, 1: block can accept an entry.
- in_pc, in, PC_W: instruction PC.
- in_en, in, 1: instruction enable.
- in_br_flag, in, 1: branch-delay flag.
- in_mem_op, in, 2: memory operation.
- in_mem_wr_data, in, DATA_W: store data.
- in_ctrl_op, in, 2: control operation.
- in_dst_addr, in, REG_W: destination GPR address.
- in_gpr_we_, in, 1: GPR write enable, active-low.
- in_exp_code, in, EXP_W: upstream exception code.
- alu_out, in, DATA_W: ALU result.
- alu_of, in, 1: arithmetic overflow.
- int_detect, in, 1: external interrupt pending.
- flush, in, 1: discard all held entries.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream accepts the head entry.
- out_pc, out_en, out_br_flag, out_mem_op, out_mem_wr_data, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_result: out, widths matching the in_ fields; out_result has DATA_W.
- occupancy, out, 2: number of held entries (0..DEPTH).

Function
REQ-003 An accept SHALL occur when in_valid&&in_ready; a pop SHALL occur when out_valid&&out_ready.
REQ-004 in_ready SHALL be a registered signal equal to (occupancy<DEPTH), so it never depends combinationally on out_ready.
REQ-005 Entries SHALL leave in acceptance order; an accept into an empty block SHALL make out_valid 1 on the next cycle.
REQ-006 A simultaneous accept and pop SHALL leave occupancy unchanged.
REQ-007 A pop with DEPTH=2 and two entries held SHALL promote the skid entry to head in the same edge.
REQ-008 Capture transform, priority high to low:
- int_detect=1: exp_code=EXP_EXT_INT.
- in_exp_code!=EXP_NO_EXP: keep the upstream code.
- alu_of=1: exp_code=EXP_OVERFLOW.
- otherwise: pass all fields; result=alu_out.
REQ-009 In the first three cases the captured entry SHALL be squashed: mem_op=MEM_OP_NOP, ctrl_op=CTRL_OP_NOP, dst_addr=0, gpr_we_=1, mem_wr_data=0, result=0. pc, en and br_flag SHALL still pass through.
REQ-010 The capture transform SHALL sample int_detect and alu_of only in the accept cycle.
REQ-011 flush=1 SHALL clear all entries on that edge to the reset values and discard any accept in the same cycle; occupancy=0 and in_ready=1 SHALL follow on the next cycle.
REQ-012 out_* fields SHALL come directly from the head register, with no combinational path from any in_* port.
REQ-013 When out_valid=0, out_* fields SHALL hold their reset values.

Reset
REQ-014 reset=1 SHALL set, on the next rising edge: out_valid=0, occupancy=0, in_ready=1, out_pc=0, out_en=0, out_br_flag=0, out_mem_op=MEM_OP_NOP, out_mem_wr_data=0, out_ctrl_op=CTRL_OP_NOP, out_dst_addr=0, out_gpr_we_=1, out_exp_code=EXP_NO_EXP, out_result=0.
REQ-015 reset SHALL take priority over flush, accept and pop; reset mid-transfer SHALL drop all held entries.

Structure
REQ-016 Package cpu_pkg SHALL hold MEM_OP_NOP=2'b00, CTRL_OP_NOP=2'b00, EXP_NO_EXP=3'd0, EXP_EXT_INT=3'd1, EXP_UNDEF_INSN=3'd2, EXP_OVERFLOW=3'd3, and the packed ex_entry_t struct.
REQ-017 The capture transform SHALL be one combinational sub-module, ex_exc_squash; the block SHALL contain all storage.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- Plain pass: accept pc=0x10, alu_out=0x1234, gpr_we_=0, dst=7, out_ready=1 -> next cycle out_valid=1, out_result=0x1234, out_dst_addr=7, exp=0.
- Interrupt over overflow: accept with alu_of=1, int_detect=1, mem_op=2'b01 -> out_exp_code=1, out_mem_op=0, out_gpr_we_=1, out_pc=0x10.
- Upstream exception kept: in_exp_code=2, alu_of=1 -> out_exp_code=2, out_result=0.
- Back-pressure: out_ready=0, three back-to-back accept attempts (DEPTH=2) -> occupancy 1 then 2, in_ready=0, third entry not taken; out_ready=1 -> entries emerge in order.
- Flush with simultaneous accept at occupancy=2 -> next cycle occupancy=0, out_valid=0, in_ready=1, no entry emerges.
- Reset mid-stream at occupancy=1 -> all outputs equal REQ-014 values on the next cycle.
